div_unit: RTL

Iterative 32-bit signed/unsigned divider for the EX stage. It produces the quotient and remainder that feed the HI/LO register writes: quotient goes to LO and remainder to HI. It runs one radix-2 restoring step per cycle and stalls the pipeline while it runs. A flush cancels it.

---
 rtl/div_unit_pkg.sv | 13 +
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encodings and constants for the iterative divider
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    localparam int   DIV_STEPS  = 32;
    localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] dvd,
    input  logic [31:0] dsr,
    output logic [31:0] rem_next,
    output logic [31:0] dvd_next
);

    logic [32:0] partial;
    logic [32:0] diff;

    assign partial = {rem, dvd[31]};
    assign diff    = partial - {1'b0, dsr};

    // rem < dsr is invariant, so a kept difference or a kept partial always fits in 32 bits
    always_comb begin
        rem_next = partial[31:0];
        dvd_next = {dvd[30:0], 1'b0};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            dvd_next = {dvd[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned divider producing LO (quotient) and HI (remainder)
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    div_state_t  state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem, dvd, dsr, raw_dvd;
    logic        neg_q, neg_r, dbz;
    logic [31:0] step_rem, step_dvd;
    logic [31:0] q_fix, r_fix;
    logic        take, last;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

    div_step u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dsr      (dsr),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    assign take    = (state == DIV_IDLE) && start_i && !cancel_i;
    assign last    = (cnt == 6'(DIV_STEPS - 1));
    assign stall_o = take || (state == DIV_BUSY);
    assign valid_o = (state == DIV_DONE) && !cancel_i;

    // INT_MIN / -1 needs no special case: the magnitude path yields 0x8000_0000 either way
    assign q_fix = dbz ? 32'hFFFF_FFFF : (neg_q ? neg32(step_dvd) : step_dvd);
    assign r_fix = dbz ? raw_dvd       : (neg_r ? neg32(step_rem) : step_rem);

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (take) state_nxt = DIV_BUSY;
            DIV_BUSY: begin
                if (cancel_i)  state_nxt = DIV_IDLE;
                else if (last) state_nxt = DIV_DONE;
            end
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state       <= DIV_IDLE;
            cnt         <= 6'd0;
            rem         <= 32'd0;
            dvd         <= 32'd0;
            dsr         <= 32'd0;
            raw_dvd     <= 32'd0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            quotient_o  <= 32'd0;
            remainder_o <= 32'd0;
        end else begin
            state <= state_nxt;
            if (take) begin
                cnt     <= 6'd0;
                rem     <= 32'd0;
                dvd     <= abs32(dividend_i, signed_i);
                dsr     <= abs32(divisor_i, signed_i);
                raw_dvd <= dividend_i;
                neg_q   <= signed_i && (dividend_i[31] ^ divisor_i[31]);
                neg_r   <= signed_i && dividend_i[31];
                dbz     <= (divisor_i == 32'd0);
            end else if (state == DIV_BUSY && !cancel_i) begin
                rem <= step_rem;
                dvd <= step_dvd;
                cnt <= cnt + 6'd1;
                if (last) begin
                    quotient_o  <= q_fix;
                    remainder_o <= r_fix;
                end
            end
        end
    end

endmodule
